// File: rtl/coeff_unpack_stream_if.sv
// Handshake bundle between the packed-word feeder, the coefficient unpacker and the
// downstream coefficient consumer. The unpacker takes the slave view.
interface coeff_unpack_stream_if #(
  parameter int DATA_W = 64
);
  logic [DATA_W-1:0] din;
  logic              dinValid;
  logic              dinReady;
  logic [12:0]       coeff;
  logic              coeffValid;
  logic              coeffReady;
  logic              coeffLast;

  modport slave (
    input  din, dinValid, coeffReady,
    output dinReady, coeff, coeffValid, coeffLast
  );

  modport master (
    output din, dinValid, coeffReady,
    input  dinReady, coeff, coeffValid, coeffLast
  );
endinterface

// File: rtl/coeff_unpack_stream.sv
// Unpacks a stream of packed DATA_W-bit words into N_COEFF 10- or 13-bit Saber
// coefficients, one zero-extended 13-bit coefficient per output handshake.
module coeff_unpack_stream #(
  parameter int DATA_W  = 64,
  parameter int N_COEFF = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic                 i_tenBitCoeff,
  coeff_unpack_stream_if.slave bus,
  output logic                 o_done
);
  localparam int BUF_W  = DATA_W + 12;
  localparam int CNT_W  = $clog2(DATA_W + 13);
  localparam int WT13   = N_COEFF * 13 / DATA_W;
  localparam int WT10   = N_COEFF * 10 / DATA_W;
  localparam int WCNT_W = $clog2(WT13 + 1);
  localparam int CCNT_W = (N_COEFF > 1) ? $clog2(N_COEFF) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [BUF_W-1:0]  r_buf;
  logic [CNT_W-1:0]  r_cnt;
  logic [WCNT_W-1:0] r_wcnt;
  logic [CCNT_W-1:0] r_ccnt;
  logic              r_tenBit;
  logic              r_done;

  logic [CNT_W-1:0]  w_width;
  logic [WCNT_W-1:0] w_wordTotal;
  logic              w_accept;
  logic              w_emit;
  logic              w_lastEmit;
  logic [CNT_W-1:0]  w_base;
  logic [BUF_W-1:0]  w_shifted;
  logic [BUF_W-1:0]  w_keepMask;
  logic [BUF_W-1:0]  w_insert;

  assign w_width     = r_tenBit ? CNT_W'(10) : CNT_W'(13);
  assign w_wordTotal = r_tenBit ? WCNT_W'(WT10) : WCNT_W'(WT13);
  assign w_accept    = bus.dinValid && bus.dinReady;
  assign w_emit      = bus.coeffValid && bus.coeffReady;
  assign w_lastEmit  = w_emit && (r_ccnt == CCNT_W'(N_COEFF - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (i_start) w_nextState = RUN;
      RUN:     if (w_lastEmit) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Handshake outputs depend on registered state only, so there is no din-to-coeff path.
  always_comb begin
    bus.dinReady   = 1'b0;
    bus.coeffValid = 1'b0;
    bus.coeffLast  = 1'b0;
    bus.coeff      = '0;
    if (r_state == RUN) begin
      bus.dinReady   = (r_cnt <= CNT_W'(12)) && (r_wcnt < w_wordTotal);
      bus.coeffValid = (r_cnt >= w_width);
      bus.coeffLast  = bus.coeffValid && (r_ccnt == CCNT_W'(N_COEFF - 1));
      if (bus.coeffValid) bus.coeff = r_tenBit ? {3'b000, r_buf[9:0]} : r_buf[12:0];
    end
  end

  assign o_done = r_done;

  // When a word arrives together with an emit, the shift happens first and din lands
  // just above the remaining valid bits.
  assign w_shifted  = w_emit ? (r_buf >> w_width) : r_buf;
  assign w_base     = w_emit ? (r_cnt - w_width) : r_cnt;
  assign w_keepMask = ~({BUF_W{1'b1}} << w_base);
  assign w_insert   = BUF_W'(bus.din) << w_base;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_buf    <= '0;
      r_cnt    <= '0;
      r_wcnt   <= '0;
      r_ccnt   <= '0;
      r_tenBit <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (i_start) begin
          r_tenBit <= i_tenBitCoeff;
          r_buf    <= '0;
          r_cnt    <= '0;
          r_wcnt   <= '0;
          r_ccnt   <= '0;
        end
      end else begin
        if (w_accept) begin
          r_buf  <= (w_shifted & w_keepMask) | w_insert;
          r_cnt  <= w_base + CNT_W'(DATA_W);
          r_wcnt <= r_wcnt + 1'b1;
        end else if (w_emit) begin
          r_buf <= w_shifted;
          r_cnt <= w_base;
        end
        if (w_emit)     r_ccnt <= r_ccnt + 1'b1;
        if (w_lastEmit) r_done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_coeff_unpack_stream.sv
// Bench for coeff_unpack_stream: directed packing vectors plus randomized full
// polynomials compared against a bit-level software unpack of the driven words.
module tb_coeff_unpack_stream;
  localparam int DATA_W  = 64;
  localparam int N_COEFF = 256;

  typedef struct {
    bit          ten;
    logic [63:0] w0;
    logic [63:0] w1;
    int          idx;
    logic [12:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic tenBitCoeff;
  logic done;

  coeff_unpack_stream_if #(.DATA_W(DATA_W)) bus ();

  coeff_unpack_stream #(.DATA_W(DATA_W), .N_COEFF(N_COEFF)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (start),
    .i_tenBitCoeff (tenBitCoeff),
    .bus           (bus),
    .o_done        (done)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] polyWords [64];
  logic [12:0] gotCoeff [N_COEFF];
  int          accepted;
  int          emitted;
  vec_t        vecs[$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Software unpack: coefficient idx occupies stream bits [idx*W +: W], word 0 lowest.
  function automatic logic [12:0] expCoeff(input int idx, input bit ten);
    int          w;
    int          b;
    logic [12:0] r;
    w = ten ? 10 : 13;
    r = '0;
    for (int k = 0; k < w; k++) begin
      b    = idx * w + k;
      r[k] = polyWords[b / DATA_W][b % DATA_W];
    end
    return r;
  endfunction

  task automatic applyStimulus(input int validPct, input int readyPct, input bit stall);
    bus.dinValid   = ($urandom_range(99) < validPct);
    bus.din        = (accepted < 64) ? polyWords[accepted] : {$urandom, $urandom};
    bus.coeffReady = !stall && ($urandom_range(99) < readyPct);
  endtask

  task automatic runPoly(input bit ten, input int validPct, input int readyPct,
                         input int stallAt, input int resetAt, input int startAt);
    int w;
    int wt;
    int held;
    int stallLeft;
    int cycles;
    bit finished;
    bit stalled;
    bit pulsed;
    w         = ten ? 10 : 13;
    wt        = N_COEFF * w / DATA_W;
    accepted  = 0;
    emitted   = 0;
    stallLeft = 0;
    cycles    = 0;
    finished  = 1'b0;
    stalled   = 1'b0;
    pulsed    = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; tenBitCoeff = ten; bus.dinValid = 1'b0; bus.coeffReady = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    while (!finished && cycles < 5000) begin
      if (emitted == resetAt) begin
        rst_n = 1'b0; bus.dinValid = 1'b0; bus.coeffReady = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_din_ready", bus.dinReady, 0);
        checkOutput("rst_coeff_valid", bus.coeffValid, 0);
        checkOutput("rst_coeff_last", bus.coeffLast, 0);
        checkOutput("rst_coeff", bus.coeff, 0);
        checkOutput("rst_done", done, 0);
        repeat (5) begin
          @(negedge clk);
          checkOutput("abort_no_done", done, 0);
        end
        @(posedge clk); #1;
        return;
      end
      if (emitted == stallAt && !stalled) begin
        stalled   = 1'b1;
        stallLeft = 20;
      end
      // Start pulse and mode toggle mid-run must be ignored; the model keeps the original mode.
      if (emitted == startAt && !pulsed) begin
        pulsed = 1'b1; start = 1'b1; tenBitCoeff = !ten;
      end else begin
        start = 1'b0;
      end
      applyStimulus(validPct, readyPct, stallLeft > 0);
      if (stallLeft > 0) stallLeft--;
      @(negedge clk);
      held = accepted * DATA_W - emitted * w;
      checkOutput("din_ready", bus.dinReady, (held <= 12) && (accepted < wt));
      checkOutput("coeff_valid", bus.coeffValid, held >= w);
      checkOutput("done_early", done, 0);
      if (bus.coeffValid) begin
        checkOutput($sformatf("coeff[%0d]", emitted), bus.coeff, expCoeff(emitted, ten));
        checkOutput("coeff_last", bus.coeffLast, emitted == N_COEFF - 1);
      end
      if (bus.dinValid && bus.dinReady) accepted++;
      if (bus.coeffValid && bus.coeffReady) begin
        gotCoeff[emitted] = bus.coeff;
        if (emitted == N_COEFF - 1) finished = 1'b1;
        emitted++;
      end
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0; bus.dinValid = 1'b0; bus.coeffReady = 1'b0;
    checkOutput("coeffs_consumed", emitted, N_COEFF);
    checkOutput("words_accepted", accepted, wt);
    if (finished) begin
      @(negedge clk);
      checkOutput("done_pulse", done, 1);
      checkOutput("din_ready_after", bus.dinReady, 0);
      checkOutput("coeff_valid_after", bus.coeffValid, 0);
      @(negedge clk);
      checkOutput("done_one_cycle", done, 0);
      checkOutput("din_ready_idle", bus.dinReady, 0);
      @(posedge clk); #1;
    end
  endtask

  task automatic randomWords();
    for (int i = 0; i < 64; i++) polyWords[i] = {$urandom, $urandom};
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; tenBitCoeff = 1'b0;
    bus.din = '0; bus.dinValid = 1'b0; bus.coeffReady = 1'b0;
    accepted = 0; emitted = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_din_ready", bus.dinReady, 0);
    checkOutput("reset_coeff_valid", bus.coeffValid, 0);
    checkOutput("reset_coeff_last", bus.coeffLast, 0);
    checkOutput("reset_coeff", bus.coeff, 0);
    checkOutput("reset_done", done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) vecs.push_back('{1'b0, {64{1'b1}}, 64'h0, i, 13'h1FFF});
    vecs.push_back('{1'b0, {64{1'b1}}, 64'h0, 4, 13'h0FFF});
    for (int i = 5; i < 9; i++) vecs.push_back('{1'b0, {64{1'b1}}, 64'h0, i, 13'h0000});
    for (int i = 0; i < 6; i++) vecs.push_back('{1'b1, {64{1'b1}}, 64'h0, i, 13'h03FF});
    vecs.push_back('{1'b1, {64{1'b1}}, 64'h0, 6, 13'h000F});
    vecs.push_back('{1'b1, {64{1'b1}}, 64'h0, 7, 13'h0000});

    for (int i = 0; i < vecs.size(); i++) begin
      if (i == 0 || vecs[i].ten != vecs[i-1].ten) begin
        for (int k = 0; k < 64; k++) polyWords[k] = '0;
        polyWords[0] = vecs[i].w0;
        polyWords[1] = vecs[i].w1;
        runPoly(vecs[i].ten, 80, 80, -1, -1, -1);
      end
      checkOutput($sformatf("vec%0d_coeff%0d", i, vecs[i].idx), gotCoeff[vecs[i].idx], vecs[i].exp);
    end

    randomWords();
    runPoly(1'b0, 70, 70, -1, -1, -1);
    randomWords();
    runPoly(1'b1, 60, 80, -1, -1, -1);
    randomWords();
    runPoly(1'b0, 100, 100, 60, -1, -1);
    randomWords();
    runPoly(1'b0, 80, 80, -1, 100, -1);
    randomWords();
    runPoly(1'b0, 80, 80, -1, -1, -1);
    randomWords();
    runPoly(1'b1, 80, 80, -1, -1, 30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/coeff_unpack_stream.md
Name: coeff_unpack_stream

Overview:
- Upstream feeder of the coefficient buffer/mux stage in the Saber high-speed multiplier.
- Takes a stream of packed DATA_W-bit memory words and unpacks N_COEFF polynomial coefficients in order.
- Coefficients are 13-bit, or 10-bit when ten_bit_coeff mode is set.
- Output is one zero-extended 13-bit coefficient per handshake, with a valid/ready interface.

Parameters:
DATA_W, 64, width of packed input word
N_COEFF, 256, coefficients per polynomial

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous reset, active low
start  input  1  one-cycle pulse; begins unpacking one polynomial
ten_bit_coeff  input  1  coefficient width select (1 = 10-bit, 0 = 13-bit); sampled at start
din  input  DATA_W  packed word, little-endian bit order
din_valid  input  1  din holds a word
din_ready  output  1  block accepts din this cycle
coeff  output  13  current coefficient, zero-extended when 10-bit
coeff_valid  output  1  coeff is valid
coeff_ready  input  1  downstream consumes coeff this cycle
coeff_last  output  1  high with coeff_valid on coefficient N_COEFF-1
done  output  1  one-cycle pulse after the last coefficient is consumed

Behaviour:
- Reset (rst_n=0 at clk edge):
  - State goes to IDLE.
  - Bit buffer and all counters clear.
  - Latched mode clears to 0.
  - Outputs din_ready, coeff_valid, coeff_last and done are 0; coeff is 0.
  - Reset mid-polynomial abandons the polynomial with no done pulse.
- Internal state:
  - W = 10 or 13 per latched mode.
  - Bit buffer buf[DATA_W+11:0].
  - Bit count cnt, range 0..DATA_W+12.
  - Word counter wcnt.
  - Coefficient counter ccnt, range 0..N_COEFF-1.
  - Total words WT = N_COEFF*W/DATA_W: 52 for 13-bit, 40 for 10-bit at defaults. Parameter choices that are not exact multiples are unsupported.
- States:
  - IDLE: all handshake outputs 0. start=1 moves to RUN, latches ten_bit_coeff, and clears cnt, wcnt and ccnt.
  - RUN: the unpacking state. start is ignored while in RUN.
- din_ready = RUN && cnt <= 12 && wcnt < WT.
  - Combinational from registers only; it must not depend on din_valid.
- coeff_valid = RUN && cnt >= W.
  - coeff = buf[W-1:0], zero-extended to 13 bits. In 10-bit mode bits [12:10] are 0.
- Word accept (din_valid && din_ready): din is written at bit position cnt' (defined below); cnt' increases by DATA_W; wcnt increments.
- Coefficient emit (coeff_valid && coeff_ready): buf shifts right by W; cnt decreases by W; ccnt increments.
- Simultaneous accept and emit in the same cycle:
  - Shift first, then insert din at cnt' = cnt - W.
  - Next cnt = cnt - W + DATA_W.
  - Insertion bits above the new cnt are don't-care; bits above cnt are masked or zero when inserting.
- Latency: a word accepted at edge t makes its first coefficient visible on coeff/coeff_valid in the cycle after t. There is no combinational din-to-coeff path.
- Packing order: coefficient 0 is din[W-1:0] of the first word. Coefficients that straddle a word boundary take their low bits from the earlier word.
- coeff_last = coeff_valid && ccnt == N_COEFF-1.
- When the last coefficient is emitted, state goes to IDLE and done pulses 1 for exactly the next cycle.
  - cnt is 0 at that point by construction.
  - A start arriving in that same cycle is honoured and starts the next polynomial.
- Downstream stall (coeff_ready=0): coeff stays stable, and din stops being accepted once cnt > 12. No data loss or reordering.
- Upstream gap (din_valid=0): coeff_valid drops when cnt < W and resumes when the next word arrives.

Test Plan:
- 13-bit mode, start, word0 = 64'hFFFF_FFFF_FFFF_FFFF, word1 = 0, coeff_ready=1 -> coeffs 0..3 = 13'h1FFF; coeff 4 = 13'h0FFF (straddles word boundary); coeffs 5..8 = 0.
- 10-bit mode, word0 = all ones, word1 = 0 -> coeffs 0..5 = 13'h03FF; coeff 6 = 13'h000F; coeff 7 = 0; bits [12:10] always 0.
- Full polynomial, 13-bit, random words, random din_valid and coeff_ready -> exactly 52 words accepted and 256 coefficients match the software unpack. coeff_last is on coefficient 255 only; done pulses once, one cycle after; din_ready is 0 thereafter.
- coeff_ready held 0 for 20 cycles mid-stream -> coeff stable; din_ready falls when cnt > 12; no words lost on resume.
- rst_n=0 for one cycle at coefficient 100 -> all outputs 0 next cycle; a new start with fresh words unpacks correctly from coefficient 0; no done pulse from the aborted run.
- start pulsed during RUN and ten_bit_coeff toggled mid-run -> ignored; mode and counters unaffected.
